// File: rtl/ram_io_responder_pkg.sv
// Shared definitions for the CPU memory-bus responder: I/O window map and byte type.
`default_nettype none

package ram_io_responder_pkg;

  typedef logic [7:0] byte_t;

  localparam logic [1:0]  IO_SEL    = 2'b11;
  localparam logic [17:0] IO_BASE   = 18'h30000;
  localparam logic [17:0] IO_UART   = 18'd0;
  localparam logic [17:0] IO_CLOCK  = 18'd4;

  localparam logic [17:0] UART_ADDR  = IO_BASE + IO_UART;
  localparam logic [17:0] CLOCK_ADDR = IO_BASE + IO_CLOCK;

endpackage

`default_nettype wire

// File: rtl/ram_io_responder_fifo.sv
// byte_fifo: synchronous first-word-fall-through byte FIFO with free-entry count.
`default_nettype none

module byte_fifo
  import ram_io_responder_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  byte_t         push_data_i,
  input  logic          pop_i,
  output byte_t         pop_data_o,
  output logic          push_ok_o,
  output logic          pop_ok_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] free_o
);

  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic [CW-1:0] count;
  byte_t         mem_q [DEPTH];

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign count      = wr_q - rd_q;
  assign full_o     = (count == CW'(DEPTH));
  assign empty_o    = (wr_q == rd_q);
  assign free_o     = CW'(DEPTH) - count;
  assign pop_ok_o   = pop_i && !empty_o;
  assign push_ok_o  = push_i && (!full_o || pop_ok_o);
  assign pop_data_o = empty_o ? byte_t'(8'h00) : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok_o) wr_d = wr_q + 1'b1;
    if (pop_ok_o)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok_o) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/ram_io_responder.sv
// Memory-bus target: main RAM plus I/O window (UART RX/TX, cycle counter, program stop).
// Optional RAM_IO_CYCLE_COUNTER_EN builds the 32-bit cycle counter and its read snapshot.
`default_nettype none

module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_W  = 17,
  parameter int TX_DEPTH    = 16,
  parameter int RX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halted,
  output logic        tx_overflow
);

  localparam int TXC = $clog2(TX_DEPTH) + 1;
  localparam int RXC = $clog2(RX_DEPTH) + 1;

  logic [17:0] a18;
  logic        io_sel, uart_hit, clk_hit, clk_base_hit;
  logic        unused_addr;

  assign a18          = mem_a[17:0];
  assign io_sel       = (a18[17:16] == IO_SEL);
  assign uart_hit     = (a18 == UART_ADDR);
  assign clk_base_hit = (a18 == CLOCK_ADDR);
  assign clk_hit      = (a18[17:2] == CLOCK_ADDR[17:2]);
  assign unused_addr  = ^mem_a[31:18];

  // ---------------- TX path ----------------
  logic          tx_push, tx_pop, tx_push_ok, tx_pop_ok, tx_full, tx_empty;
  byte_t         tx_push_data, tx_head;
  logic [TXC-1:0] tx_free, tx_free_next;

  assign tx_push      = mem_wr && ((uart_hit && (mem_dout != 8'h00)) || clk_base_hit);
  assign tx_push_data = uart_hit ? mem_dout : 8'h00;
  assign tx_pop       = tx_valid && tx_ready;
  assign tx_valid     = !tx_empty;
  assign tx_data      = tx_head;

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i       (clk_in),
    .rst_ni      (rst_in),
    .push_i      (tx_push),
    .push_data_i (tx_push_data),
    .pop_i       (tx_pop),
    .pop_data_o  (tx_head),
    .push_ok_o   (tx_push_ok),
    .pop_ok_o    (tx_pop_ok),
    .full_o      (tx_full),
    .empty_o     (tx_empty),
    .free_o      (tx_free)
  );

  assign tx_free_next = tx_free + TXC'(tx_pop_ok) - TXC'(tx_push_ok);

  // ---------------- RX path ----------------
  logic          rx_push, rx_pop, rx_push_ok, rx_pop_ok, rx_full, rx_empty;
  byte_t         rx_head;
  logic [RXC-1:0] rx_free;

  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = !mem_wr && uart_hit;

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i       (clk_in),
    .rst_ni      (rst_in),
    .push_i      (rx_push),
    .push_data_i (rx_data),
    .pop_i       (rx_pop),
    .pop_data_o  (rx_head),
    .push_ok_o   (rx_push_ok),
    .pop_ok_o    (rx_pop_ok),
    .full_o      (rx_full),
    .empty_o     (rx_empty),
    .free_o      (rx_free)
  );

  logic unused_rx;
  assign unused_rx = rx_push_ok ^ rx_pop_ok ^ rx_empty ^ (^rx_free);

  // ---------------- Cycle counter ----------------
  byte_t clk_rd;
`ifdef RAM_IO_CYCLE_COUNTER_EN
  logic [31:0] cnt_q, snap_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q  <= '0;
      snap_q <= '0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
      if (!mem_wr && clk_base_hit) snap_q <= cnt_q;
    end
  end

  // Byte 0 comes straight from the live count, which is what the snapshot captures.
  always_comb begin
    clk_rd = 8'h00;
    case (a18[1:0])
      2'd0:    clk_rd = cnt_q[7:0];
      2'd1:    clk_rd = snap_q[15:8];
      2'd2:    clk_rd = snap_q[23:16];
      default: clk_rd = snap_q[31:24];
    endcase
  end
`else
  assign clk_rd = 8'h00;
`endif

  // ---------------- RAM and read mux ----------------
  byte_t ram_q [2**RAM_ADDR_W];
  logic  run_q;
  byte_t mem_din_q, mem_din_d;
  logic  halted_q, halted_d, ovf_q, ovf_d, io_full_q, io_full_d;

  always_comb begin
    mem_din_d = 8'h00;
    if (!io_sel)       mem_din_d = ram_q[mem_a[RAM_ADDR_W-1:0]];
    else if (mem_wr)   mem_din_d = 8'h00;
    else if (uart_hit) mem_din_d = rx_head;
    else if (clk_hit)  mem_din_d = clk_rd;
  end

  always_comb begin
    halted_d  = halted_q || (mem_wr && clk_base_hit);
    ovf_d     = ovf_q || (tx_push && tx_full && !tx_pop);
    io_full_d = (int'(tx_free_next) <= FULL_MARGIN);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_din_q <= 8'h00;
      halted_q  <= 1'b0;
      ovf_q     <= 1'b0;
      io_full_q <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      mem_din_q <= mem_din_d;
      halted_q  <= halted_d;
      ovf_q     <= ovf_d;
      io_full_q <= io_full_d;
      run_q     <= 1'b1;
    end
  end

  // run_q drops asynchronously with reset, so an edge taken under reset cannot write RAM.
  always_ff @(posedge clk_in) begin
    if (run_q && mem_wr && !io_sel) ram_q[mem_a[RAM_ADDR_W-1:0]] <= mem_dout;
  end

  assign mem_din        = mem_din_q;
  assign halted         = halted_q;
  assign tx_overflow    = ovf_q;
  assign io_buffer_full = io_full_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_io_responder.sv
// Scoreboard bench for ram_io_responder: read and TX expectations are queued at drive time.
`default_nettype none

module tb_ram_io_responder;
  import ram_io_responder_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] mem_a = '0;
  logic [7:0]  mem_dout = '0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        halted;
  logic        tx_overflow;

  int errors = 0;
  int checks = 0;
  logic [7:0] rdq [$];
  logic [7:0] txq [$];

  ram_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .halted         (halted),
    .tx_overflow    (tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // TX consumer: a byte is taken at the next rising edge whenever valid && ready here.
  always @(negedge clk_in) begin
    if (rst_in && tx_valid && tx_ready) begin
      chk("tx_expected", (txq.size() != 0), 1);
      if (txq.size() != 0) chk("tx_data", tx_data, txq.pop_front());
    end
  end

  task automatic bus_write(input logic [31:0] addr, input logic [7:0] d);
    mem_a = addr; mem_dout = d; mem_wr = 1'b1;
    @(posedge clk_in); #1;
    mem_wr = 1'b0; mem_a = '0; mem_dout = '0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [7:0] d);
    mem_a = addr; mem_wr = 1'b0;
    @(posedge clk_in); #1;
    d = mem_din;
    mem_a = '0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [7:0] exp);
    logic [7:0] d;
    rdq.push_back(exp);
    bus_read(addr, d);
    chk(tag, d, rdq.pop_front());
  endtask

  task automatic tx_write(input logic [7:0] d);
    if (d != 8'h00) txq.push_back(d);
    bus_write(32'h30000, d);
  endtask

  task automatic rx_send(input logic [7:0] d);
    rx_valid = 1'b1; rx_data = d;
    @(posedge clk_in); #1;
    rx_valid = 1'b0;
  endtask

  task automatic drain_tx();
    tx_ready = 1'b1;
    for (int i = 0; i < 200 && txq.size() != 0; i++) @(posedge clk_in);
    #1;
    chk("tx_drained", txq.size(), 0);
  endtask

  initial begin
    logic [7:0]  b;
    logic [31:0] snap;

    // Reset state
    #12;
    chk("rst_mem_din", mem_din, 8'h00);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_full", io_buffer_full, 0);
    chk("rst_halted", halted, 0);
    chk("rst_ovf", tx_overflow, 0);
    @(negedge clk_in); rst_in = 1'b1;
    @(posedge clk_in); #1;

    // RAM: write then read with one-cycle latency
    bus_write(32'h00010, 8'hA5);
    rd_check("ram_a5", 32'h00010, 8'hA5);
    for (int i = 0; i < 4; i++) bus_write(32'h1FFF0 + i, 8'(8'h3C + 8'(i * 17)));
    for (int i = 0; i < 4; i++) rd_check("ram_pat", 32'h1FFF0 + i, 8'(8'h3C + 8'(i * 17)));
    rd_check("ram_keep", 32'h00010, 8'hA5);

    // Unmapped I/O
    bus_write(32'h30008, 8'h99);
    rd_check("io_other", 32'h30008, 8'h00);
    chk("io_other_notx", tx_valid, 0);

    // TX with zero-byte filtering
    tx_ready = 1'b1;
    tx_write(8'h41); tx_write(8'h00); tx_write(8'h42);
    drain_tx();

    // TX fill with consumer stalled
    tx_ready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      if (i <= 16) txq.push_back(8'(i));
      bus_write(32'h30000, 8'(i));
      if (i == 13) chk("full_13", io_buffer_full, 0);
      if (i == 14) chk("full_14", io_buffer_full, 1);
      if (i == 16) chk("ovf_16", tx_overflow, 0);
      if (i == 17) chk("ovf_17", tx_overflow, 1);
    end
    drain_tx();
    chk("full_after_drain", io_buffer_full, 0);

    // RX path
    rx_send(8'h33);
    rd_check("rx_33", 32'h30000, 8'h33);
    rd_check("rx_empty", 32'h30000, 8'h00);
    rx_send(8'h01); rx_send(8'h02); rx_send(8'h03);
    rd_check("rx_1", 32'h30000, 8'h01);
    rd_check("rx_2", 32'h30000, 8'h02);
    rd_check("rx_3", 32'h30000, 8'h03);
    // Pop on empty with concurrent push returns 0 and keeps the byte
    rx_valid = 1'b1; rx_data = 8'h5A;
    rd_check("rx_pushpop_empty", 32'h30000, 8'h00);
    rx_valid = 1'b0;
    rd_check("rx_kept", 32'h30000, 8'h5A);

    // Halt and reset mid-stream
    tx_ready = 1'b0;
    bus_write(32'h00020, 8'h11);
    tx_write(8'h55); tx_write(8'h66);
    txq.push_back(8'h00);
    bus_write(32'h30004, 8'h7F);
    chk("halted_set", halted, 1);
    chk("halt_head", tx_data, 8'h55);
    drain_tx();
    tx_ready = 1'b0;
    tx_write(8'h77);
    mem_a = 32'h00020; mem_dout = 8'hEE; mem_wr = 1'b1;
    #3 rst_in = 1'b0;
    #1;
    chk("rst_mid_halted", halted, 0);
    chk("rst_mid_tx_valid", tx_valid, 0);
    chk("rst_mid_tx_data", tx_data, 8'h00);
    txq.delete();
    @(posedge clk_in); #1;
    mem_wr = 1'b0; mem_a = '0;
    @(negedge clk_in); rst_in = 1'b1;

    // Counter snapshot 100 cycles after reset
    repeat (100) @(posedge clk_in);
    #1;
    bus_read(32'h30004, b); snap[7:0]   = b;
    bus_read(32'h30005, b); snap[15:8]  = b;
    bus_read(32'h30006, b); snap[23:16] = b;
    bus_read(32'h30007, b); snap[31:24] = b;
`ifdef RAM_IO_CYCLE_COUNTER_EN
    chk("cnt_range", (snap >= 32'd98 && snap <= 32'd102), 1);
`else
    chk("cnt_zero", snap, 32'd0);
`endif
    rd_check("ram_write_discarded", 32'h00020, 8'h11);
    chk("post_rst_ovf", tx_overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
